// File: rtl/ysyx_22041211_pc_gen.sv
// Fetch PC generator: sequential step, trap/branch redirects with alignment check,
// accepted-fetch counter and a terminal HALT state.
module ysyx_22041211_pc_gen #(
  parameter int unsigned DATA_LEN   = 32,
  parameter logic [63:0] RST_PC     = 64'h8000_0000,
  parameter int unsigned STEP       = 4,
  parameter int unsigned ALIGN_BITS = 2,
  parameter int unsigned CNT_LEN    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_ready,
  input  logic                redirect_valid,
  input  logic [DATA_LEN-1:0] redirect_pc,
  input  logic                trap_valid,
  input  logic [DATA_LEN-1:0] trap_pc,
  input  logic                halt,
  output logic [DATA_LEN-1:0] pc_o,
  output logic                pc_valid,
  output logic                halted,
  output logic                misalign,
  output logic [CNT_LEN-1:0]  fetch_cnt
);

  localparam logic [DATA_LEN-1:0] RESET_PC   = DATA_LEN'(RST_PC);
  localparam logic [DATA_LEN-1:0] STEP_INC   = DATA_LEN'(STEP);
  localparam logic [DATA_LEN-1:0] ALIGN_MASK = DATA_LEN'((65'd1 << ALIGN_BITS) - 65'd1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [DATA_LEN-1:0]   pc_n;
  logic [DATA_LEN-1:0]   target;
  logic                  take;
  logic                  fire;
  logic                  mis_n;
  logic [CNT_LEN-1:0]    cnt_n;

  // State and output registers; pc_valid/halted are registered copies of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc_o      <= RESET_PC;
      pc_valid  <= 1'b0;
      halted    <= 1'b0;
      misalign  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_n;
      pc_o      <= pc_n;
      pc_valid  <= (state_n == RUN);
      halted    <= (state_n == HALT);
      misalign  <= mis_n;
      fetch_cnt <= cnt_n;
    end
  end

  // Next-state, next-PC and counter; halt outranks trap, trap outranks branch
  always_comb begin
    state_n = state;
    pc_n    = pc_o;
    mis_n   = misalign;
    cnt_n   = fetch_cnt;
    target  = '0;
    take    = 1'b0;
    fire    = pc_valid & pc_ready;

    case (state)
      BOOT, RUN: begin
        if (fire) begin
          cnt_n = fetch_cnt + CNT_LEN'(1);
        end
        if (state == BOOT) begin
          state_n = RUN;
        end
        if (trap_valid) begin
          target = trap_pc;
          take   = 1'b1;
        end else if (redirect_valid) begin
          target = redirect_pc;
          take   = 1'b1;
        end

        if (halt) begin
          state_n = HALT;
        end else if (take) begin
          if ((target & ALIGN_MASK) != '0) begin
            mis_n   = 1'b1;
            state_n = HALT;
          end else begin
            pc_n = target;
          end
        end else if (fire) begin
          pc_n = pc_o + STEP_INC;
        end
      end
      default: begin
        state_n = HALT;
      end
    endcase
  end

endmodule
